// File: rtl/l2_arbiter.sv
// Arbitrates the single L2 line port between the L1 I-cache and D-cache miss paths.
// One transaction in flight; round-robin or fixed D-priority on ties; response routed to the grantee.
module l2_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int D_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT_I,
        S_GNT_D,
        S_RELEASE
    } state_t;

    state_t state, state_nxt;
    logic   last_d;     // 1: most recent grant went to the D-cache
    logic   d_req;
    logic   grant_i, grant_d, done;

    assign d_req    = d_read | d_write;
    assign arb_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_read && d_req) begin
                    // On a tie, round-robin hands the port to whoever did not have it last
                    if ((D_PRIORITY != 0) || !last_d) grant_d = 1'b1;
                    else                              grant_i = 1'b1;
                end else if (i_read) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) state_nxt = S_GNT_I;
                if (grant_d) state_nxt = S_GNT_D;
            end
            S_GNT_I, S_GNT_D: begin
                if (l2_ready) begin
                    done      = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d   <= 1'b1;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (grant_i) begin
                l2_read  <= 1'b1;
                l2_write <= 1'b0;
                l2_addr  <= i_addr;
                last_d   <= 1'b0;
            end
            if (grant_d) begin
                // A simultaneous read+write is treated as a write-back only
                l2_write <= d_write;
                l2_read  <= ~d_write;
                l2_addr  <= d_addr;
                l2_wdata <= d_wdata;
                last_d   <= 1'b1;
            end
            if (done) begin
                l2_read  <= 1'b0;
                l2_write <= 1'b0;
                if (state == S_GNT_I) begin
                    i_rdata <= l2_rdata;
                    i_ready <= 1'b1;
                end else begin
                    d_rdata <= l2_rdata;
                    d_ready <= 1'b1;
                end
            end
        end
    end

endmodule
